// File: rtl/mouse_bus_pkg.sv
// Shared definitions for the bus-mapped mouse peripheral: register offsets,
// PS/2 status bit positions, control bit positions and interrupt FSM states.
package mouse_bus_pkg;

  localparam logic [2:0] OffStatus = 3'd0;
  localparam logic [2:0] OffPosX   = 3'd1;
  localparam logic [2:0] OffPosY   = 3'd2;
  localparam logic [2:0] OffDx     = 3'd3;
  localparam logic [2:0] OffDy     = 3'd4;
  localparam logic [2:0] OffCtrl   = 3'd5;

  localparam int unsigned XSignBit = 4;
  localparam int unsigned YSignBit = 5;
  localparam int unsigned XOvfBit  = 6;
  localparam int unsigned YOvfBit  = 7;

  localparam int unsigned CtrlIrqEnBit    = 0;
  localparam int unsigned CtrlRecentreBit = 1;
  localparam int unsigned CtrlClrOvrBit   = 2;

  typedef enum logic {
    StIdle,
    StRaised
  } irq_state_e;

endpackage

// File: rtl/axis_accumulator.sv
// One cursor axis: adds a 9-bit signed PS/2 delta to the position and clamps
// the result to [0, Max]; a recentre request overrides any packet.
module axis_accumulator #(
  parameter logic [7:0] Max    = 8'd159,
  parameter logic [7:0] Centre = 8'd80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] delta,
  input  logic       sign,
  input  logic       overflow,
  input  logic       valid,
  input  logic       recentre,
  output logic [7:0] pos
);

  logic [7:0]        pos_q, pos_d;
  logic signed [9:0] step;
  logic signed [9:0] sum;

  always_comb begin
    step  = overflow ? 10'sd0 : $signed({sign, sign, delta});
    sum   = $signed({2'b00, pos_q}) + step;
    pos_d = pos_q;
    if (recentre) begin
      pos_d = Centre;
    end else if (valid) begin
      if (sum < 10'sd0) begin
        pos_d = 8'd0;
      end else if (sum > $signed({2'b00, Max})) begin
        pos_d = Max;
      end else begin
        pos_d = sum[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= Centre;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/bus_interface_mouse.sv
// Bus-mapped mouse peripheral: latches PS/2 packets, tracks a clamped cursor,
// exposes six read registers and raises a level interrupt per packet.
module bus_interface_mouse
  import mouse_bus_pkg::*;
#(
  parameter logic [7:0] BaseAddr = 8'hA0,
  parameter logic [7:0] MaxX     = 8'd159,
  parameter logic [7:0] MaxY     = 8'd119
) (
  input  logic       CLK,
  input  logic       RESETN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  input  logic [7:0] MOUSE_STATUS,
  input  logic [7:0] MOUSE_DX,
  input  logic [7:0] MOUSE_DY,
  input  logic       MOUSE_VALID
);

  localparam logic [7:0] CentreX = 8'((int'(MaxX) + 1) / 2);
  localparam logic [7:0] CentreY = 8'((int'(MaxY) + 1) / 2);

  logic [7:0] offset;
  logic       in_window, rd_en, ctrl_wr, recentre, clr_ovr, ovr_event;
  logic [7:0] status_q, dx_q, dy_q, rdata_q, rd_mux, pos_x, pos_y;
  logic       irq_en_q, overrun_q, overrun_d, drive_q;
  logic       unused_wdata;
  irq_state_e state_q, state_d;

  // Addresses below BaseAddr wrap to large offsets and fall outside the window.
  assign offset    = BUS_ADDR - BaseAddr;
  assign in_window = offset < 8'd6;
  assign rd_en     = in_window && !BUS_WE;
  assign ctrl_wr   = in_window && BUS_WE && (offset[2:0] == OffCtrl);
  assign recentre  = ctrl_wr && BUS_DATA[CtrlRecentreBit];
  assign clr_ovr   = ctrl_wr && BUS_DATA[CtrlClrOvrBit];
  assign unused_wdata = ^BUS_DATA[7:3];

  axis_accumulator #(.Max(MaxX), .Centre(CentreX)) u_axis_x (
    .clk      (CLK),
    .rst_n    (RESETN),
    .delta    (MOUSE_DX),
    .sign     (MOUSE_STATUS[XSignBit]),
    .overflow (MOUSE_STATUS[XOvfBit]),
    .valid    (MOUSE_VALID),
    .recentre (recentre),
    .pos      (pos_x)
  );

  axis_accumulator #(.Max(MaxY), .Centre(CentreY)) u_axis_y (
    .clk      (CLK),
    .rst_n    (RESETN),
    .delta    (MOUSE_DY),
    .sign     (MOUSE_STATUS[YSignBit]),
    .overflow (MOUSE_STATUS[YOvfBit]),
    .valid    (MOUSE_VALID),
    .recentre (recentre),
    .pos      (pos_y)
  );

  always_comb begin
    rd_mux = 8'h00;
    case (offset[2:0])
      OffStatus: rd_mux = status_q;
      OffPosX:   rd_mux = pos_x;
      OffPosY:   rd_mux = pos_y;
      OffDx:     rd_mux = dx_q;
      OffDy:     rd_mux = dy_q;
      OffCtrl:   rd_mux = {6'b0, overrun_q, irq_en_q};
      default:   rd_mux = 8'h00;
    endcase
  end

  // An ACK arriving with a packet consumes the old request, so no overrun.
  assign ovr_event = MOUSE_VALID && (state_q == StRaised) && !BUS_INTERRUPT_ACK;

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    if (clr_ovr) overrun_d = 1'b0;
    if (ovr_event) overrun_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (MOUSE_VALID && irq_en_q) state_d = StRaised;
      end
      StRaised: begin
        if (BUS_INTERRUPT_ACK) state_d = (MOUSE_VALID && irq_en_q) ? StRaised : StIdle;
      end
    endcase
    BUS_INTERRUPT_RAISE = (state_q == StRaised);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      status_q  <= 8'h00;
      dx_q      <= 8'h00;
      dy_q      <= 8'h00;
      irq_en_q  <= 1'b1;
      overrun_q <= 1'b0;
      state_q   <= StIdle;
      drive_q   <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      if (MOUSE_VALID) begin
        status_q <= MOUSE_STATUS;
        dx_q     <= MOUSE_DX;
        dy_q     <= MOUSE_DY;
      end
      if (ctrl_wr) irq_en_q <= BUS_DATA[CtrlIrqEnBit];
      overrun_q <= overrun_d;
      state_q   <= state_d;
      drive_q   <= rd_en;
      if (rd_en) rdata_q <= rd_mux;
    end
  end

  assign BUS_DATA = drive_q ? rdata_q : 8'bz;

endmodule

// File: doc/bus_interface_mouse.md
# bus_interface_mouse

Bus-mapped mouse peripheral on the 8-bit processor bus, at the same level as the LED bus interface. It captures decoded PS/2 packets from the mouse transceiver and accumulates a clamped cursor position. It exposes raw and accumulated data as read registers and raises a bus interrupt per packet. The processor services that interrupt and writes the results onward to the LED and display peripherals.

## Interface
- `BaseAddr`, `8'hA0`: first register address; the block decodes `BaseAddr`..`BaseAddr+5`.
- `MaxX`, `8'd159`: upper X clamp (inclusive).
- `MaxY`, `8'd119`: upper Y clamp (inclusive).

- `CLK`  in  1  system clock; all logic on the rising edge.
- `RESETN`  in  1  synchronous, active-low reset.
- `BUS_DATA`  inout  8  shared data bus; driven only during this block's read cycles, otherwise `Z`.
- `BUS_ADDR`  in  8  bus address from the processor.
- `BUS_WE`  in  1  bus write enable; 1 = write, 0 = read.
- `BUS_INTERRUPT_RAISE`  out  1  level interrupt request to the processor.
- `BUS_INTERRUPT_ACK`  in  1  one-cycle acknowledge from the processor.
- `MOUSE_STATUS`  in  8  PS/2 byte 0: bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow, bits2:0 buttons.
- `MOUSE_DX`  in  8  PS/2 byte 1, low 8 bits of the 9-bit X delta.
- `MOUSE_DY`  in  8  PS/2 byte 2, low 8 bits of the 9-bit Y delta.
- `MOUSE_VALID`  in  1  one-cycle pulse; the three bytes are valid in that cycle.

## Operation
- Register map (offset from `BaseAddr`):
  - 0: status, R; holds the last `MOUSE_STATUS`.
  - 1: X position, R.
  - 2: Y position, R.
  - 3: raw DX, R.
  - 4: raw DY, R.
  - 5: control/flags. Read returns {6'b0, overrun, irq_en}. A write: bit0 → `irq_en`; bit1 = 1 recentres the position; bit2 = 1 clears `overrun`.
- Writes to offsets 0–4 are ignored. Addresses outside the window are neither decoded nor driven.
- On `MOUSE_VALID`:
  - Latch status, DX and DY.
  - Form the 9-bit signed delta {sign, byte}.
  - If the axis overflow bit is set, force that axis delta to 0.
  - `pos_next = pos + delta` computed at 10 bits signed, then clamped to [0, Max]. X clamps to `MaxX`, Y clamps to `MaxY`.
- Interrupt FSM:
  - IDLE → RAISED on `MOUSE_VALID` when `irq_en` = 1.
  - RAISED → IDLE on `BUS_INTERRUPT_ACK`.
  - `MOUSE_VALID` in RAISED sets `overrun`. The registers still update.
- Reset values:
  - X = (`MaxX`+1)/2 = 80; Y = (`MaxY`+1)/2 = 60.
  - status, DX, DY = 0.
  - `irq_en` = 1; `overrun` = 0.
  - FSM = IDLE; `BUS_INTERRUPT_RAISE` = 0.
  - bus drive enable = 0, so `BUS_DATA` = `Z`.
- A reset mid-operation returns every value above to its reset value at the next edge. A pending interrupt is dropped.

## Timing
- Read: the address is in the window with `BUS_WE` = 0 at edge N. Read data and the drive enable are registered at edge N. `BUS_DATA` is driven for cycle N→N+1 and released afterwards unless the read repeats.
- Write: takes effect at the edge where the address matches with `BUS_WE` = 1. The block never drives the bus during a write.
- Packet: `MOUSE_VALID` high at edge N → registers and position updated at edge N. `BUS_INTERRUPT_RAISE` is high from N+1.
- Simultaneous events:
  - ACK and VALID in the same cycle while RAISED: the request stays raised and `overrun` is not set. The new packet is treated as the next event.
  - Recentre write and VALID in the same cycle: recentre wins for the position; raw registers still latch.
  - Clear-overrun write and an overrun event in the same cycle: `overrun` = 1.
  - An `irq_en` = 0 write while RAISED does not lower the request; only ACK does.

## Structure
- Shared package `mouse_bus_pkg`:
  - register offset constants 0–5;
  - status bit-index constants (sign, overflow);
  - FSM state encoding (IDLE, RAISED).
- One sub-module, `axis_accumulator`, instantiated twice (X, Y). It is parameterised by Max and Centre and takes delta, sign, overflow, valid and recentre. It outputs the 8-bit position.

## Test plan
- Reset, then read offsets 1, 2, 5 → 80, 60, `8'h01`; `BUS_DATA` = `Z` outside read cycles.
- VALID with status=`8'h00`, DX=5, DY=3 → X=85, Y=63; RAISE high the next cycle; ACK → RAISE low one cycle later.
- Status=`8'h10`, DX=`8'h9C` (−100) from X=80 → X=0. Then +255 three times → X=159.
- Status=`8'h40`, DX=50 → X unchanged; raw DX reads 50.
- Two VALIDs with no ACK between → `overrun` = 1 (offset 5 reads `8'h03`). Writing `8'h05` clears it and leaves `irq_en` = 1.
- Write `8'h00` to offset 5, then VALID → no RAISE. Write `8'h02` concurrent with VALID → X=80, Y=60.
